aes_stream_adapter: RTL and testbench
=====================================

Name: aes_stream_adapter

Overview:
Upstream/downstream adapter for the AES core. It accepts a word stream of key and plaintext words over a valid/ready handshake and packs them into 128-bit key and text blocks. It drives the core's ld/key/text_in pins and waits for done. It then captures text_out and returns the result as a word stream over a second valid/ready handshake. One block is in flight at a time.

Parameters:
WORD_W, 32, stream word width; legal 8, 16, 32, 64; WPB = 128/WORD_W words per block.
DONE_TIMEOUT, 64, max cycles to wait for aes_done after aes_ld; legal range 2..1023.

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  upstream word valid
in_ready  out  1  adapter accepts word (transfer = in_valid & in_ready)
in_data  in  WORD_W  upstream word
in_is_key  in  1  1 = key word, 0 = text word; qualified by in_valid
out_valid  out  1  result word valid
out_ready  in  1  downstream accepts word
out_data  out  WORD_W  result word
out_last  out  1  final word of a result block
aes_ld  out  1  one-cycle load pulse to core
aes_key  out  128  key to core
aes_text_in  out  128  text block to core
aes_kdone  in  1  core key expansion done
aes_done  in  1  core block done
aes_text_out  in  128  core result
key_loaded  out  1  a complete key is held
key_expanded  out  1  registered aes_kdone, cleared on new key
busy  out  1  state != COLLECT
err_sync  out  1  one-cycle pulse: partial block discarded
err_timeout  out  1  one-cycle pulse: aes_done not seen in time

Behaviour:
- Reset (rst=0, async): state COLLECT, word counter 0, key_loaded 0, key_expanded 0. All outputs 0, including aes_key, aes_text_in, out_data, the errors and in_ready. in_ready goes 1 on the first clock after reset release.
- Packing is big-endian: the first word accepted goes to bits [127:128-WORD_W], and the last word goes to [WORD_W-1:0].
- States: COLLECT, LOAD, BUSY, DRAIN.
- COLLECT:
  - in_ready=1, except when a full text block is held and key_loaded=0. In that case in_ready=0 until a key exists; this cannot occur by construction, see the next rule.
  - Text words arriving while key_loaded=0 are accepted and packed. When the block completes without a key, the block is dropped and err_sync pulses.
  - The counter tracks the type of the current partial block. A word whose in_is_key differs from the partial type (counter != 0) discards the partial block and pulses err_sync. That word then starts a new block at counter 1.
  - When the key block completes: aes_key updates, key_loaded=1, key_expanded=0. The state stays COLLECT.
  - When the text block completes with key_loaded=1: aes_text_in updates and the next state is LOAD.
- LOAD: aes_ld=1 for exactly one cycle, asserted the cycle after the last text word is accepted. aes_key and aes_text_in are held stable from LOAD until leaving BUSY. Next state is BUSY and the timeout counter clears.
- BUSY:
  - In the first cycle aes_done is sampled high, aes_text_out is captured into the result register and the next state is DRAIN.
  - If the counter reaches DONE_TIMEOUT first: err_timeout pulses, the block is discarded and the next state is COLLECT. The key is kept.
- DRAIN:
  - out_valid=1, and out_data shows result word i, MSB-first, with i starting at 0.
  - i advances on out_valid & out_ready. out_data and out_valid hold while out_ready=0.
  - out_last=1 when i=WPB-1. A transfer with out_last set returns the state to COLLECT, and in_ready=1 on the next cycle.
- aes_kdone is sampled every cycle. key_expanded is set on aes_kdone=1 and cleared when a new key completes; if both happen in the same cycle, the clear wins.
- Minimum block latency, with out_ready tied high: last in word accepted to first out word = 2 + core latency cycles.
- Mid-operation reset: all state aborts immediately, and no aes_ld or output word is emitted after rst deasserts.

Decomposition:
- Package aes_adapter_pkg:
  - state enum (COLLECT, LOAD, BUSY, DRAIN)
  - BLOCK_W=128 constant
  - function computing WPB
  - typedef for the block vector.
- One sub-module, aes_word_packer: a shift-in register plus word counter and type tracking, instanced for input. The output side is an index mux in the top level.

Test Plan:
1. WORD_W=32: key words 0x2b7e1516,0x28aed2a6,0xabf71588,0x09cf4f3c, then 4 text words.
   - Required: aes_key=0x2b7e151628aed2a6abf7158809cf4f3c, and a single aes_ld pulse the cycle after the 8th accept.
   - With the core model returning 0x3925841d02dc09fbdc118597196a0b32, out words come MSB-first, out_last is set on the 4th, and in_ready rises the next cycle.
2. Backpressure: hold out_ready=0 for 10 cycles in DRAIN -> out_data stable at word 0, out_valid held high; toggle out_ready randomly -> all 4 words delivered in order, none duplicated.
3. Type switch: 2 text words, then a key word -> err_sync one-cycle pulse, counter=1 with that key word, and no aes_ld issued.
4. Timeout: core never asserts done -> err_timeout pulses exactly DONE_TIMEOUT=64 cycles after aes_ld, state returns to COLLECT, and key_loaded stays 1.
5. Text block with no key after reset -> err_sync pulse and no aes_ld; a following key plus text block then produces a normal result.
6. Assert rst=0 during BUSY, and again during DRAIN at word 2 -> all outputs go to 0 immediately, with no further aes_ld/out_valid until new input arrives. Also check key_expanded clears on a new key when aes_kdone is high in the same cycle.

Source files
------------

// File: rtl/aes_adapter_pkg.sv
// Shared types and constants for the AES stream adapter and its word packer.
package aes_adapter_pkg;

    localparam int BLOCK_W = 128;

    typedef logic [BLOCK_W-1:0] block_t;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        LOAD    = 2'd1,
        BUSY    = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    function automatic int wordsPerBlock(input int wordW);
        return BLOCK_W / wordW;
    endfunction

endpackage

// File: rtl/aes_word_packer.sv
// Big-endian shift-in packer: collects WPB words of one type (key or text) into a block.
module aes_word_packer
    import aes_adapter_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_accept,
    input  logic [WORD_W-1:0] i_data,
    input  logic              i_isKey,
    output block_t            o_block,
    output logic              o_complete,
    output logic              o_isKey,
    output logic              o_mismatch
);

    localparam int WPB   = wordsPerBlock(WORD_W);
    localparam int CNT_W = $clog2(WPB + 1);

    logic [CNT_W-1:0] r_count;
    logic             r_isKey;
    block_t           r_shift;

    logic             w_typeMismatch;
    logic [CNT_W-1:0] w_countBase;

    // A word of the other type restarts packing, so it counts from zero.
    always_comb begin
        w_typeMismatch = (r_count != '0) && (i_isKey != r_isKey);
        w_countBase    = w_typeMismatch ? '0 : r_count;
        o_mismatch     = i_accept && w_typeMismatch;
        o_complete     = i_accept && (w_countBase == CNT_W'(WPB - 1));
        o_isKey        = i_isKey;
        o_block        = {r_shift[BLOCK_W-WORD_W-1:0], i_data};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
            r_isKey <= 1'b0;
            r_shift <= '0;
        end else if (i_accept) begin
            r_shift <= o_block;
            r_isKey <= i_isKey;
            r_count <= o_complete ? '0 : (w_countBase + CNT_W'(1));
        end
    end

endmodule

// File: rtl/aes_stream_adapter.sv
// Word-stream front end for the AES core: packs key/text blocks, sequences ld/done,
// and streams the result back out MSB-first.
module aes_stream_adapter
    import aes_adapter_pkg::*;
#(
    parameter int WORD_W       = 32,
    parameter int DONE_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_is_key,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last,
    output logic              aes_ld,
    output logic [127:0]      aes_key,
    output logic [127:0]      aes_text_in,
    input  logic              aes_kdone,
    input  logic              aes_done,
    input  logic [127:0]      aes_text_out,
    output logic              key_loaded,
    output logic              key_expanded,
    output logic              busy,
    output logic              err_sync,
    output logic              err_timeout
);

    localparam int WPB   = wordsPerBlock(WORD_W);
    localparam int IDX_W = $clog2(WPB);
    localparam int LOG_W = $clog2(WORD_W);
    localparam int SH_W  = IDX_W + LOG_W;
    localparam int TMR_W = 10;

    state_t            r_state;
    state_t            w_nextState;
    logic              r_inReady;
    logic              r_keyLoaded;
    logic              r_keyExpanded;
    block_t            r_aesKey;
    block_t            r_aesText;
    block_t            r_result;
    logic [IDX_W-1:0]  r_outIdx;
    logic [TMR_W-1:0]  r_timer;
    logic              r_errSync;

    logic              w_accept;
    block_t            w_packBlock;
    logic              w_packComplete;
    logic              w_packIsKey;
    logic              w_packMismatch;
    logic              w_keyDone;
    logic              w_textDone;
    logic              w_dropText;
    logic              w_outFire;
    logic              w_outLastIdx;
    logic              w_timeoutHit;
    logic [SH_W-1:0]   w_shAmt;
    block_t            w_resultShift;
    logic [WORD_W-1:0] w_outWord;

    assign w_accept = in_valid && r_inReady;

    aes_word_packer #(
        .WORD_W (WORD_W)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .i_accept   (w_accept),
        .i_data     (in_data),
        .i_isKey    (in_is_key),
        .o_block    (w_packBlock),
        .o_complete (w_packComplete),
        .o_isKey    (w_packIsKey),
        .o_mismatch (w_packMismatch)
    );

    always_comb begin
        w_keyDone     = w_packComplete && w_packIsKey;
        w_textDone    = w_packComplete && !w_packIsKey;
        w_dropText    = w_textDone && !r_keyLoaded;
        w_outFire     = (r_state == DRAIN) && out_ready;
        w_outLastIdx  = (r_outIdx == IDX_W'(WPB - 1));
        w_timeoutHit  = (r_state == BUSY) && !aes_done
                        && (r_timer == TMR_W'(DONE_TIMEOUT - 1));
        w_shAmt       = {r_outIdx, {LOG_W{1'b0}}};
        w_resultShift = r_result << w_shAmt;
        w_outWord     = w_resultShift[BLOCK_W-1 -: WORD_W];
    end

    // Next-state and state-decoded outputs; done takes priority over timeout.
    always_comb begin
        w_nextState = r_state;
        aes_ld      = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        out_data    = '0;
        err_timeout = 1'b0;
        busy        = (r_state != COLLECT);
        case (r_state)
            COLLECT: begin
                if (w_textDone && r_keyLoaded) begin
                    w_nextState = LOAD;
                end
            end
            LOAD: begin
                aes_ld      = 1'b1;
                w_nextState = BUSY;
            end
            BUSY: begin
                if (aes_done) begin
                    w_nextState = DRAIN;
                end else if (w_timeoutHit) begin
                    err_timeout = 1'b1;
                    w_nextState = COLLECT;
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_last  = w_outLastIdx;
                out_data  = w_outWord;
                if (w_outFire && w_outLastIdx) begin
                    w_nextState = COLLECT;
                end
            end
            default: w_nextState = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= COLLECT;
            r_inReady     <= 1'b0;
            r_keyLoaded   <= 1'b0;
            r_keyExpanded <= 1'b0;
            r_aesKey      <= '0;
            r_aesText     <= '0;
            r_result      <= '0;
            r_outIdx      <= '0;
            r_timer       <= '0;
            r_errSync     <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_inReady <= (w_nextState == COLLECT);
            r_errSync <= w_packMismatch || w_dropText;

            if (w_keyDone) begin
                r_aesKey    <= w_packBlock;
                r_keyLoaded <= 1'b1;
            end
            // A freshly completed key must be re-expanded, so its clear beats kdone.
            if (w_keyDone) begin
                r_keyExpanded <= 1'b0;
            end else if (aes_kdone) begin
                r_keyExpanded <= 1'b1;
            end

            if (w_textDone && r_keyLoaded) begin
                r_aesText <= w_packBlock;
            end

            if (r_state == LOAD) begin
                r_timer <= '0;
            end else if (r_state == BUSY) begin
                r_timer <= r_timer + TMR_W'(1);
            end

            if ((r_state == BUSY) && aes_done) begin
                r_result <= aes_text_out;
            end

            if (w_outFire) begin
                r_outIdx <= w_outLastIdx ? '0 : (r_outIdx + IDX_W'(1));
            end
        end
    end

    assign in_ready     = r_inReady;
    assign aes_key      = r_aesKey;
    assign aes_text_in  = r_aesText;
    assign key_loaded   = r_keyLoaded;
    assign key_expanded = r_keyExpanded;
    assign err_sync     = r_errSync;

endmodule

// File: tb/tb_aes_stream_adapter.sv
// Directed bench for aes_stream_adapter (WORD_W=32) with a simple AES core model.
module tb_aes_stream_adapter;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_data;
    logic          in_is_key;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic          out_last;
    logic          aes_ld;
    logic [127:0]  aes_key;
    logic [127:0]  aes_text_in;
    logic          aes_kdone;
    logic          aes_done;
    logic [127:0]  aes_text_out;
    logic          key_loaded;
    logic          key_expanded;
    logic          busy;
    logic          err_sync;
    logic          err_timeout;

    int errors = 0;
    int checks = 0;

    int cyc = 0;
    int ldCount = 0;
    int ldCycle = 0;
    int syncCount = 0;
    int toCount = 0;
    int toCycle = 0;
    int outCount = 0;
    logic [31:0] outQ[$];

    logic          coreEnable = 1'b1;
    int            coreLatency = 1;
    logic [127:0]  coreResult = '0;

    localparam logic [127:0] KEY_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] TEXT_A = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] RES_A  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] RES_B  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B  = 128'hcafef00d_13572468_a5a5a5a5_0f1e2d3c;
    localparam logic [127:0] RES_C  = 128'hdeadbeef_01234567_89abcdef_fedcba98;

    aes_stream_adapter #(
        .WORD_W       (32),
        .DONE_TIMEOUT (64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_is_key    (in_is_key),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .aes_ld       (aes_ld),
        .aes_key      (aes_key),
        .aes_text_in  (aes_text_in),
        .aes_kdone    (aes_kdone),
        .aes_done     (aes_done),
        .aes_text_out (aes_text_out),
        .key_loaded   (key_loaded),
        .key_expanded (key_expanded),
        .busy         (busy),
        .err_sync     (err_sync),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    // Event monitor: counts pulses and records delivered output words at each edge.
    always @(posedge clk) begin
        cyc++;
        if (aes_ld === 1'b1) begin
            ldCount++;
            ldCycle = cyc;
        end
        if (err_sync === 1'b1) syncCount++;
        if (err_timeout === 1'b1) begin
            toCount++;
            toCycle = cyc;
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            outCount++;
            outQ.push_back(out_data);
        end
    end

    // Core model: answers each ld with a one-cycle done after coreLatency cycles.
    initial begin
        aes_done     = 1'b0;
        aes_text_out = '0;
        forever begin
            @(posedge clk);
            if (aes_ld === 1'b1 && coreEnable) begin
                repeat (coreLatency - 1) @(posedge clk);
                #1;
                aes_done     = 1'b1;
                aes_text_out = coreResult;
                @(posedge clk);
                #1;
                aes_done = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkInt(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic isKey, input logic [31:0] data);
        int n;
        @(negedge clk);
        in_valid  = 1'b1;
        in_is_key = isKey;
        in_data   = data;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checkBit("inReadyWait", in_ready, 1'b1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic sendBlock(input logic isKey, input logic [127:0] blk);
        logic [127:0] b;
        b = blk;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(isKey, b[127-32*i -: 32]);
        end
    endtask

    task automatic waitOutValid(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (out_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkBit(tag, out_valid, 1'b1);
    endtask

    initial begin
        logic [127:0] exp;
        int ldBase;
        int syncBase;
        int toBase;
        int outBase;
        int n;

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_is_key = 1'b0;
        out_ready = 1'b1;
        aes_kdone = 1'b0;

        // Reset state
        #2;
        checkBit("rstInReady", in_ready, 1'b0);
        checkBit("rstBusy", busy, 1'b0);
        checkBit("rstOutValid", out_valid, 1'b0);
        checkOutput("rstKey", aes_key, '0);
        checkOutput("rstOutData", 128'(out_data), '0);
        checkBit("rstKeyLoaded", key_loaded, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkBit("inReadyAfterRst", in_ready, 1'b1);

        // Text block with no key: dropped with err_sync, no ld
        sendBlock(1'b0, TEXT_A);
        @(negedge clk);
        checkBit("noKeyErrSync", err_sync, 1'b1);
        checkBit("noKeyLd", aes_ld, 1'b0);
        @(negedge clk);
        checkBit("noKeyErrSyncEnd", err_sync, 1'b0);
        checkInt("noKeyLdCount", ldCount, 0);
        checkBit("noKeyLoaded", key_loaded, 1'b0);

        // Key load, then normal block with 1-cycle core latency
        sendBlock(1'b1, KEY_A);
        @(negedge clk);
        checkBit("keyLoaded", key_loaded, 1'b1);
        checkOutput("keyValue", aes_key, KEY_A);
        checkBit("keyNotBusy", busy, 1'b0);
        aes_kdone = 1'b1;
        @(negedge clk);
        aes_kdone = 1'b0;
        checkBit("keyExpandedSet", key_expanded, 1'b1);

        outQ.delete();
        coreResult  = RES_A;
        coreLatency = 1;
        sendBlock(1'b0, TEXT_A);
        @(negedge clk);
        checkBit("ldPulse", aes_ld, 1'b1);
        checkOutput("ldText", aes_text_in, TEXT_A);
        checkOutput("ldKey", aes_key, KEY_A);
        checkBit("ldInReady", in_ready, 1'b0);
        @(negedge clk);
        checkBit("ldSingle", aes_ld, 1'b0);
        checkBit("busyHigh", busy, 1'b1);
        exp = RES_A;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkBit("outValidA", out_valid, 1'b1);
            checkOutput("outDataA", 128'(out_data), 128'(exp[127-32*i -: 32]));
            checkBit("outLastA", out_last, (i == 3));
        end
        @(negedge clk);
        checkBit("drainDoneValid", out_valid, 1'b0);
        checkBit("drainDoneInReady", in_ready, 1'b1);
        checkInt("ldCountA", ldCount, 1);
        checkInt("outCountA", outQ.size(), 4);

        // Backpressure: hold in DRAIN, then random out_ready
        outQ.delete();
        out_ready   = 1'b0;
        coreResult  = RES_B;
        coreLatency = 3;
        sendBlock(1'b0, TEXT_A);
        waitOutValid("bpWaitValid");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("bpHoldData", 128'(out_data), 128'(32'h00112233));
            checkBit("bpHoldValid", out_valid, 1'b1);
        end
        n = 0;
        while (outQ.size() < 4 && n < 200) begin
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkInt("bpCount", outQ.size(), 4);
        exp = RES_B;
        for (int i = 0; i < 4; i++) begin
            if (i < outQ.size()) begin
                checkOutput("bpOrder", 128'(outQ[i]), 128'(exp[127-32*i -: 32]));
            end
        end
        checkBit("bpIdle", out_valid, 1'b0);

        // Type switch: two text words then a key word
        ldBase   = ldCount;
        syncBase = syncCount;
        applyStimulus(1'b0, 32'h11111111);
        applyStimulus(1'b0, 32'h22222222);
        applyStimulus(1'b1, KEY_B[127:96]);
        @(negedge clk);
        checkBit("switchErrSync", err_sync, 1'b1);
        @(negedge clk);
        checkBit("switchErrSyncEnd", err_sync, 1'b0);
        applyStimulus(1'b1, KEY_B[95:64]);
        applyStimulus(1'b1, KEY_B[63:32]);
        applyStimulus(1'b1, KEY_B[31:0]);
        @(negedge clk);
        checkOutput("switchNewKey", aes_key, KEY_B);
        checkInt("switchSyncCount", syncCount - syncBase, 1);
        checkInt("switchNoLd", ldCount, ldBase);

        // Timeout: core never answers
        coreEnable = 1'b0;
        toBase     = toCount;
        sendBlock(1'b0, TEXT_A);
        n = 0;
        while (toCount == toBase && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        checkInt("timeoutPulses", toCount - toBase, 1);
        checkInt("timeoutDelay", toCycle - ldCycle, 64);
        checkBit("timeoutIdle", busy, 1'b0);
        checkBit("timeoutKeyKept", key_loaded, 1'b1);
        checkBit("timeoutInReady", in_ready, 1'b1);

        // Reset during BUSY
        sendBlock(1'b0, TEXT_A);
        repeat (5) @(negedge clk);
        checkBit("preRstBusy", busy, 1'b1);
        rst = 1'b0;
        #1;
        checkBit("rstBusyBusy", busy, 1'b0);
        checkBit("rstBusyLd", aes_ld, 1'b0);
        checkOutput("rstBusyKey", aes_key, '0);
        checkOutput("rstBusyText", aes_text_in, '0);
        checkBit("rstBusyInReady", in_ready, 1'b0);
        checkBit("rstBusyKeyLoaded", key_loaded, 1'b0);
        @(negedge clk);
        rst     = 1'b1;
        ldBase  = ldCount;
        outBase = outCount;
        repeat (20) @(negedge clk);
        checkInt("rstBusyNoLd", ldCount, ldBase);
        checkInt("rstBusyNoOut", outCount, outBase);

        // kdone and new key in the same cycle: clear wins
        aes_kdone = 1'b1;
        @(negedge clk);
        checkBit("kdoneSet", key_expanded, 1'b1);
        sendBlock(1'b1, KEY_B);
        aes_kdone = 1'b0;
        @(negedge clk);
        checkBit("kdoneClearWins", key_expanded, 1'b0);
        checkBit("kdoneKeyLoaded", key_loaded, 1'b1);

        // Reset during DRAIN at word 2
        coreEnable  = 1'b1;
        coreLatency = 2;
        coreResult  = RES_C;
        out_ready   = 1'b0;
        sendBlock(1'b0, TEXT_A);
        waitOutValid("drainWaitValid");
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        checkOutput("drainWord2", 128'(out_data), 128'(32'h89abcdef));
        rst = 1'b0;
        #1;
        checkBit("rstDrainValid", out_valid, 1'b0);
        checkOutput("rstDrainData", 128'(out_data), '0);
        checkBit("rstDrainLast", out_last, 1'b0);
        @(negedge clk);
        rst       = 1'b1;
        out_ready = 1'b1;
        ldBase    = ldCount;
        outBase   = outCount;
        repeat (20) @(negedge clk);
        checkInt("rstDrainNoOut", outCount, outBase);
        checkInt("rstDrainNoLd", ldCount, ldBase);
        checkBit("rstDrainInReady", in_ready, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
